// File: rtl/friscv_icache_lines_pkg.sv
// Shared geometry helpers for the instruction cache, used by the cache lines,
// the memory controller and the fetcher so that all of them split addresses
// the same way.
package friscv_icache_lines_pkg;

  localparam int ICACHE_ADDR_W        = 32;
  localparam int ICACHE_BLOCK_W       = 128;
  localparam int ICACHE_DEPTH         = 512;
  localparam int ICACHE_INST_W        = 32;

  // Byte offset bits inside one line
  function automatic int calc_off_w(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  // Line index bits
  function automatic int calc_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Remaining upper address bits form the tag
  function automatic int calc_tag_w(input int addr_w, input int block_w, input int depth);
    return addr_w - calc_off_w(block_w) - calc_idx_w(depth);
  endfunction

endpackage

// File: rtl/friscv_icache_lines_if.sv
// Line write port from the memory controller plus the lookup/response
// handshake towards the fetcher, bundled for the cache lines block.
interface friscv_icache_lines_if
  import friscv_icache_lines_pkg::*;
#(
  parameter int ADDR_W        = ICACHE_ADDR_W,
  parameter int CACHE_BLOCK_W = ICACHE_BLOCK_W,
  parameter int INST_W        = ICACHE_INST_W
);

  logic                     wen;
  logic [ADDR_W-1:0]        waddr;
  logic [CACHE_BLOCK_W-1:0] wdata;
  logic                     flush;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_hit;
  logic [ADDR_W-1:0]        rsp_addr;
  logic [INST_W-1:0]        rsp_inst;

  modport master (
    output wen, waddr, wdata, flush, rd_valid, rd_addr, rsp_ready,
    input  rd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_inst
  );

  modport slave (
    input  wen, waddr, wdata, flush, rd_valid, rd_addr, rsp_ready,
    output rd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_inst
  );

endinterface

// File: rtl/friscv_icache_lines_ram.sv
// Tag plus payload storage of the cache: one write port, one registered read
// port, no reset. A read hitting the index being written in the same cycle
// returns the new content so the lookup sees a same-cycle fill.
module friscv_icache_ram
  import friscv_icache_lines_pkg::*;
#(
  parameter int IDX_W  = 9,
  parameter int TAG_W  = 19,
  parameter int DATA_W = ICACHE_BLOCK_W
)(
  input  logic              aclk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  logic [TAG_W+DATA_W-1:0] mem [2**IDX_W];

  // Store tag and payload of a filled line
  always_ff @(posedge aclk) begin
    if (we) begin
      mem[widx] <= {wtag, wdata};
    end
  end

  // Read only on an accepted lookup so a held response stays stable
  always_ff @(posedge aclk) begin
    if (re) begin
      if (we && (widx == ridx)) begin
        {rtag, rdata} <= {wtag, wdata};
      end else begin
        {rtag, rdata} <= mem[ridx];
      end
    end
  end

endmodule

// File: rtl/friscv_icache_lines.sv
// Direct-mapped instruction cache lines: valid bits in flops, tag and payload
// in friscv_icache_ram, one lookup per cycle with a one-cycle response.
module friscv_icache_lines
  import friscv_icache_lines_pkg::*;
#(
  parameter int ADDR_W        = ICACHE_ADDR_W,
  parameter int CACHE_BLOCK_W = ICACHE_BLOCK_W,
  parameter int CACHE_DEPTH   = ICACHE_DEPTH,
  parameter int INST_W        = ICACHE_INST_W
)(
  input  logic                  aclk,
  input  logic                  srst,
  friscv_icache_lines_if.slave  bus
);

  localparam int OFF_W    = calc_off_w(CACHE_BLOCK_W);
  localparam int IDX_W    = calc_idx_w(CACHE_DEPTH);
  localparam int TAG_W    = calc_tag_w(ADDR_W, CACHE_BLOCK_W, CACHE_DEPTH);
  localparam int NB_WORDS = 2 ** (OFF_W - 2);

  logic [CACHE_DEPTH-1:0]   valid_q;
  logic                     rsp_valid_q;
  logic                     line_valid_q;
  logic [ADDR_W-1:0]        rsp_addr_q;
  logic                     accept;
  logic                     same_idx;
  logic [IDX_W-1:0]         widx;
  logic [IDX_W-1:0]         ridx;
  logic [TAG_W-1:0]         wtag;
  logic [TAG_W-1:0]         rtag;
  logic [CACHE_BLOCK_W-1:0] rdata;
  logic [OFF_W-1:0]         byte_off;
  logic [INST_W-1:0]        inst_sel;
  logic                     unused_waddr_off;

  assign widx     = bus.waddr[OFF_W+IDX_W-1:OFF_W];
  assign wtag     = bus.waddr[ADDR_W-1:OFF_W+IDX_W];
  assign ridx     = bus.rd_addr[OFF_W+IDX_W-1:OFF_W];
  assign same_idx = bus.wen && (widx == ridx);
  assign unused_waddr_off = ^bus.waddr[OFF_W-1:0];

  assign bus.rd_ready = ~rsp_valid_q | bus.rsp_ready;
  assign accept       = bus.rd_valid & bus.rd_ready;

  friscv_icache_ram #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (CACHE_BLOCK_W)
  ) u_ram (
    .aclk  (aclk),
    .we    (bus.wen & ~bus.flush),
    .widx  (widx),
    .wtag  (wtag),
    .wdata (bus.wdata),
    .re    (accept),
    .ridx  (ridx),
    .rtag  (rtag),
    .rdata (rdata)
  );

  // Valid bits: set on fill, cleared on flush, all cleared by reset
  always_ff @(posedge aclk) begin
    if (srst) begin
      valid_q <= '0;
    end else if (bus.wen) begin
      valid_q[widx] <= ~bus.flush;
    end
  end

  // Response slot: capture on accept, drop after handshake, hold otherwise
  always_ff @(posedge aclk) begin
    if (srst) begin
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      line_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_addr_q   <= bus.rd_addr;
      line_valid_q <= same_idx ? ~bus.flush : valid_q[ridx];
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign byte_off = rsp_addr_q[OFF_W-1:0];

  // Pick the addressed 32-bit word out of the registered line
  always_comb begin
    inst_sel = '0;
    for (int i = 0; i < NB_WORDS; i++) begin
      if ((byte_off >> 2) == OFF_W'(i)) begin
        inst_sel = rdata[i*INST_W +: INST_W];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_hit   = line_valid_q & (rtag == rsp_addr_q[ADDR_W-1:OFF_W+IDX_W]);
  assign bus.rsp_inst  = line_valid_q ? inst_sel : '0;

endmodule

// File: tb/tb_friscv_icache_lines.sv
// Directed bench for friscv_icache_lines with a reference line model and a
// response scoreboard checked on every falling edge.
module tb_friscv_icache_lines;
  import friscv_icache_lines_pkg::*;

  localparam int ADDR_W = 32;
  localparam int BLK_W  = 128;
  localparam int DEPTH  = 512;
  localparam int INST_W = 32;
  localparam int OFF_W  = calc_off_w(BLK_W);
  localparam int IDX_W  = calc_idx_w(DEPTH);
  localparam int TAG_W  = calc_tag_w(ADDR_W, BLK_W, DEPTH);

  typedef struct {
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } exp_t;

  logic aclk = 1'b0;
  logic srst;

  friscv_icache_lines_if #(.ADDR_W(ADDR_W), .CACHE_BLOCK_W(BLK_W), .INST_W(INST_W)) bus ();

  friscv_icache_lines #(
    .ADDR_W        (ADDR_W),
    .CACHE_BLOCK_W (BLK_W),
    .CACHE_DEPTH   (DEPTH),
    .INST_W        (INST_W)
  ) dut (
    .aclk (aclk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int resp_count = 0;
  int hit_count = 0;

  logic              mvalid [DEPTH];
  logic [TAG_W-1:0]  mtag   [DEPTH];
  logic [BLK_W-1:0]  mdata  [DEPTH];
  exp_t              sb [$];
  logic              exp_valid = 1'b0;
  bit                armed = 1'b0;
  exp_t              mon_e;
  logic              mon_acc;
  logic [BLK_W-1:0]  mon_data;
  int                mon_ri;

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[OFF_W+IDX_W-1:OFF_W]);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFF_W+IDX_W];
  endfunction

  function automatic logic [INST_W-1:0] word_of(input logic [BLK_W-1:0] d, input logic [ADDR_W-1:0] a);
    return d[a[OFF_W-1:2]*INST_W +: INST_W];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] wa, input logic [BLK_W-1:0] wd,
                               input logic fl, input logic rv, input logic [ADDR_W-1:0] ra, input logic rr);
    bus.wen       = w;
    bus.waddr     = wa;
    bus.wdata     = wd;
    bus.flush     = fl;
    bus.rd_valid  = rv;
    bus.rd_addr   = ra;
    bus.rsp_ready = rr;
    @(posedge aclk);
    #1;
    bus.wen      = 1'b0;
    bus.flush    = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  // Reference model and scoreboard: check outputs, then advance the model
  always @(negedge aclk) begin
    if (armed) begin
      checkOutput("rd_ready", bus.rd_ready, !exp_valid || bus.rsp_ready);
      checkOutput("rsp_valid", bus.rsp_valid, exp_valid);
      if (exp_valid && sb.size() > 0) begin
        mon_e = sb[0];
        checkOutput("rsp_hit", bus.rsp_hit, mon_e.hit);
        checkOutput("rsp_addr", bus.rsp_addr, mon_e.addr);
        if (mon_e.hit) checkOutput("rsp_inst", bus.rsp_inst, mon_e.inst);
      end
    end
    if (srst) begin
      armed = 1'b1;
      exp_valid = 1'b0;
      sb.delete();
      for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    end else if (armed) begin
      mon_acc = bus.rd_valid && (!exp_valid || bus.rsp_ready);
      if (exp_valid && bus.rsp_ready) begin
        mon_e = sb.pop_front();
        resp_count++;
        if (bus.rsp_hit) hit_count++;
      end
      if (mon_acc) begin
        mon_ri = idx_of(bus.rd_addr);
        if (bus.wen && idx_of(bus.waddr) == mon_ri) begin
          mon_e.hit = !bus.flush && (tag_of(bus.waddr) == tag_of(bus.rd_addr));
          mon_data  = bus.wdata;
        end else begin
          mon_e.hit = mvalid[mon_ri] && (mtag[mon_ri] == tag_of(bus.rd_addr));
          mon_data  = mdata[mon_ri];
        end
        mon_e.addr = bus.rd_addr;
        mon_e.inst = word_of(mon_data, bus.rd_addr);
        sb.push_back(mon_e);
      end
      exp_valid = mon_acc || (exp_valid && !bus.rsp_ready);
      if (bus.wen) begin
        if (bus.flush) begin
          mvalid[idx_of(bus.waddr)] = 1'b0;
        end else begin
          mvalid[idx_of(bus.waddr)] = 1'b1;
          mtag[idx_of(bus.waddr)]   = tag_of(bus.waddr);
          mdata[idx_of(bus.waddr)]  = bus.wdata;
        end
      end
    end
  end

  // Directed sequence
  initial begin
    logic [BLK_W-1:0]  w1;
    logic [BLK_W-1:0]  w2;
    logic [BLK_W-1:0]  wr;
    logic [ADDR_W-1:0] a;
    int c0;
    int tries;
    logic got;

    w1 = 128'h44444444_33333333_22222222_11111111;
    w2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    srst = 1'b1;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.flush = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b0;

    applyStimulus(0, 0, 0, 0, 1, 32'h1000, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_hit", bus.rsp_hit, 0);
    checkOutput("reset_rsp_addr", bus.rsp_addr, 0);
    checkOutput("reset_rsp_inst", bus.rsp_inst, 0);
    checkOutput("reset_rd_ready", bus.rd_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    srst = 1'b0;

    applyStimulus(0, 0, 0, 0, 1, 32'h1000, 1);
    checkOutput("cold_valid", bus.rsp_valid, 1);
    checkOutput("cold_hit", bus.rsp_hit, 0);

    applyStimulus(1, 32'h1000, w1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h100C, 1);
    checkOutput("fill_hit", bus.rsp_hit, 1);
    checkOutput("fill_inst", bus.rsp_inst, 32'h44444444);
    applyStimulus(0, 0, 0, 0, 1, 32'h3000, 1);
    checkOutput("other_tag_hit", bus.rsp_hit, 0);

    applyStimulus(0, 0, 0, 0, 1, 32'h1000, 1);
    checkOutput("hold_start_hit", bus.rsp_hit, 1);
    applyStimulus(1, 32'h1000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_valid", bus.rsp_valid, 1);
    checkOutput("hold_hit", bus.rsp_hit, 1);
    checkOutput("hold_inst", bus.rsp_inst, 32'h11111111);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("drop_after_handshake", bus.rsp_valid, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1000, 1);
    checkOutput("after_flush_hit", bus.rsp_hit, 0);

    applyStimulus(1, 32'h2000, w2, 0, 1, 32'h2004, 1);
    checkOutput("fwd_fill_hit", bus.rsp_hit, 1);
    checkOutput("fwd_fill_inst", bus.rsp_inst, 32'hBBBB0002);
    applyStimulus(1, 32'h2000, 0, 1, 1, 32'h2000, 1);
    checkOutput("fwd_flush_hit", bus.rsp_hit, 0);

    for (int i = 0; i < 16; i++) begin
      wr = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1, 32'h4000 + 32'(i * 16), wr, 0, 0, 0, 1);
    end
    c0 = resp_count;
    for (int i = 0; i < 16; i++) begin
      a = (i == 5) ? 32'h6050 : 32'h4000 + 32'(i * 16) + 32'((i % 4) * 4);
      applyStimulus(0, 0, 0, 0, 1, a, 1);
    end
    checkOutput("stream_consumed_15", resp_count - c0, 15);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stream_consumed_16", resp_count - c0, 16);

    c0 = resp_count;
    for (int i = 0; i < 16; i++) begin
      a = 32'h4000 + 32'(((i * 7) % 16) * 16) + 32'((i % 4) * 4);
      tries = 0;
      got = 1'b0;
      do begin
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = a;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        got = bus.rd_ready;
        @(posedge aclk);
        #1;
        tries++;
      end while (!got && tries < 50);
      bus.rd_valid = 1'b0;
      if (!got) checkOutput("random_retry_bound", got, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("random_no_loss", resp_count - c0, 16);

    for (int i = 0; i < DEPTH; i++) begin
      wr = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1, 32'h0001_0000 + 32'(i * 16), wr, 0, 0, 0, 1);
    end
    srst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 32'h0001_0000, 1);
    srst = 1'b0;
    checkOutput("pulse_reset_valid", bus.rsp_valid, 0);
    c0 = hit_count;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h0001_0000 + 32'(i * 16) + 32'((i % 4) * 4), 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("all_miss_after_reset", hit_count - c0, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/friscv_icache_lines.md
FRISCV_ICACHE_LINES -- requirements
Module: friscv_icache_lines

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: fetch and line address width.
REQ-002 SHALL have parameter CACHE_BLOCK_W, default 128: line payload width in bits; power of two, at least 32.
REQ-003 SHALL have parameter CACHE_DEPTH, default 512: number of lines; power of two.
REQ-004 SHALL have parameter INST_W, default 32: width of the returned instruction.
REQ-005 Clocking and reset, decided: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port srst  in  1  synchronous active-high reset.
REQ-008 SHALL have port wen  in  1  line write strobe from the memory controller.
REQ-009 SHALL have port waddr  in  ADDR_W  byte address of the line being written.
REQ-010 SHALL have port wdata  in  CACHE_BLOCK_W  line payload.
REQ-011 SHALL have port flush  in  1  when high, wen invalidates the line instead of filling it.
REQ-012 SHALL have port rd_valid  in  1  lookup request.
REQ-013 SHALL have port rd_ready  out  1  lookup accepted.
REQ-014 SHALL have port rd_addr  in  ADDR_W  instruction byte address.
REQ-015 SHALL have port rsp_valid  out  1  response available.
REQ-016 SHALL have port rsp_ready  in  1  response consumed.
REQ-017 SHALL have port rsp_hit  out  1  1 = hit, 0 = miss.
REQ-018 SHALL have port rsp_addr  out  ADDR_W  address of the answered lookup.
REQ-019 SHALL have port rsp_inst  out  INST_W  selected instruction; only meaningful on a hit.

Function
REQ-020 Address split SHALL be: OFF_W = log2(CACHE_BLOCK_W/8); IDX_W = log2(CACHE_DEPTH); index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[ADDR_W-1:OFF_W+IDX_W].
REQ-021 Each line SHALL store one valid bit, one tag and one payload; direct-mapped.
REQ-022 A write with wen=1 and flush=0 SHALL set valid, store tag(waddr) and store wdata at index(waddr), visible from the next cycle.
REQ-023 A write with wen=1 and flush=1 SHALL clear valid at index(waddr); tag and payload are don't-care.
REQ-024 A lookup SHALL be accepted when rd_valid and rd_ready are both 1.
REQ-025 rd_ready SHALL equal ~rsp_valid | rsp_ready; back-to-back lookups sustain one per cycle.
REQ-026 The response to an accepted lookup SHALL appear with rsp_valid=1 exactly one cycle after acceptance.
REQ-027 rsp_hit SHALL equal valid[idx] & (tag[idx]==tag(rd_addr)).
REQ-028 rsp_inst SHALL be word rd_addr[OFF_W-1:2] of the payload; word 0 is payload[INST_W-1:0]; rd_addr[1:0] is ignored.
REQ-029 While rsp_valid=1 and rsp_ready=0, rsp_hit, rsp_addr and rsp_inst SHALL hold stable, including across writes to the same index.
REQ-030 rsp_valid SHALL drop the cycle after a handshake unless a new lookup was accepted in the same cycle.
REQ-031 On a same-cycle write and accepted lookup to the same index, the response SHALL reflect the write: fill forwards wdata and tag(waddr); flush returns a miss.
REQ-032 A write to a different index SHALL not affect a lookup in flight.
REQ-033 Writes SHALL always be accepted, with no backpressure, regardless of lookup state.

Reset
REQ-034 On srst, all valid bits SHALL clear in one cycle, with rsp_valid=0, rsp_hit=0, rsp_addr=0 and rsp_inst=0.
REQ-035 rd_ready SHALL read 1 during and after reset.
REQ-036 A lookup accepted in the same cycle as srst SHALL be dropped.
REQ-037 Payload and tag RAMs SHALL not be reset.

Structure
REQ-038 The derived widths OFF_W, IDX_W and TAG_W SHALL be computed in a shared package also used by the memory controller and fetcher.
REQ-039 Payload plus tag storage SHALL be one sub-module, friscv_icache_ram: one write port, one registered read port, no reset.
REQ-040 Valid bits SHALL live in flops inside friscv_icache_lines, so that srst clears them.

Verification
REQ-041 Reset, then lookup 0x0000_1000 -> rsp_valid after 1 cycle, rsp_hit=0.
REQ-042 Fill waddr=0x1000 with wdata=0x44444444_33333333_22222222_11111111, then lookup 0x100C -> rsp_hit=1, rsp_inst=0x44444444; lookup 0x3000 (same index, other tag) -> rsp_hit=0.
REQ-043 Fill 0x1000, then hold rsp_ready=0 for 5 cycles while flush-writing 0x1000 -> response stays stable with hit=1; the next lookup of 0x1000 -> hit=0.
REQ-044 Same-cycle fill of 0x2000 and lookup of 0x2004 -> hit=1, rsp_inst = wdata[63:32]; same-cycle flush-write and lookup -> hit=0.
REQ-045 Stream 16 lookups with rsp_ready=1 -> 16 responses on 16 consecutive cycles, in order; toggle rsp_ready randomly -> no loss or duplication.
REQ-046 Fill all 512 lines, pulse srst for 1 cycle -> every lookup misses.
